sweep_scheduler: RTL and testbench

Sequences the I/Q phase detector through a stepped frequency sweep. Per step, the block programs the NCO frequency word, waits a settle interval and brackets a measurement window with two single-cycle detector triggers. It captures both detector snapshots and emits the per-window I/Q as their difference. The block sits between the host/config registers and the phase detector/NCO pair. The detector accumulates continuously and never clears between triggers, so differencing is mandatory.

---
 rtl/sweep_scheduler_if.sv | 45 ++++
 rtl/sweep_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_sweep_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sweep_scheduler_if.sv
// Host configuration, NCO/detector and result signals of the sweep scheduler.
// The scheduler uses the slave view; the host/detector side uses the master view.
interface sweep_scheduler_if #(
   parameter int FREQ_W = 32,
   parameter int STEP_W = 16,
   parameter int CNT_W  = 24
);
   logic              start;
   logic              abort;
   logic [FREQ_W-1:0] start_freq;
   logic [FREQ_W-1:0] step_freq;
   logic [STEP_W-1:0] num_steps;
   logic [CNT_W-1:0]  settle_cycles;
   logic [CNT_W-1:0]  window_cycles;

   logic [FREQ_W-1:0] freq_word;
   logic              pd_trigger;
   logic              pd_data_valid;
   logic [31:0]       pd_i;
   logic [31:0]       pd_q;

   logic              result_valid;
   logic [STEP_W-1:0] result_index;
   logic [FREQ_W-1:0] result_freq;
   logic [31:0]       result_i;
   logic [31:0]       result_q;
   logic              busy;
   logic              done;
   logic              error;
   logic              err_sticky;

   modport slave (
      input  start, abort, start_freq, step_freq, num_steps, settle_cycles, window_cycles,
      input  pd_data_valid, pd_i, pd_q,
      output freq_word, pd_trigger, result_valid, result_index, result_freq,
      output result_i, result_q, busy, done, error, err_sticky
   );

   modport master (
      output start, abort, start_freq, step_freq, num_steps, settle_cycles, window_cycles,
      output pd_data_valid, pd_i, pd_q,
      input  freq_word, pd_trigger, result_valid, result_index, result_freq,
      input  result_i, result_q, busy, done, error, err_sticky
   );
endinterface

// File: rtl/sweep_scheduler.sv
// Stepped-frequency sweep sequencer: retunes the NCO, brackets each window with two detector
// triggers and emits the snapshot difference. All outputs registered; no backpressure on results.
module sweep_scheduler #(
   parameter int FREQ_W       = 32,
   parameter int STEP_W       = 16,
   parameter int CNT_W        = 24,
   parameter int PRIME_CYCLES = 8,
   parameter int TIMEOUT      = 64
) (
   input logic              clk,
   input logic              reset_n,
   sweep_scheduler_if.slave bus
);
   localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0]  PRIME_LAST  = CNT_W'(PRIME_CYCLES - 1);
   localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT);
   localparam logic [STEP_W-1:0] STEP_ONE    = STEP_W'(1);

   typedef enum logic [2:0] {
      IDLE, PRIME, SETTLE, SNAP_A, WINDOW, SNAP_B, EMIT
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  settle_q;
   logic [CNT_W-1:0]  window_q;
   logic [FREQ_W-1:0] step_q;
   logic [STEP_W-1:0] nsteps_q;
   logic [STEP_W-1:0] index_q;
   logic [31:0]       a_i_q;
   logic [31:0]       a_q_q;

   logic [FREQ_W-1:0] freq_q;
   logic              trig_q;
   logic              res_valid_q;
   logic [STEP_W-1:0] res_index_q;
   logic [FREQ_W-1:0] res_freq_q;
   logic [31:0]       res_i_q;
   logic [31:0]       res_q_q;
   logic              busy_q;
   logic              done_q;
   logic              error_q;
   logic              sticky_q;

   logic              last_step;
   logic              window_end;
   logic              snap_hit;
   logic              snap_timeout;
   logic [FREQ_W-1:0] freq_d;

   assign last_step    = (index_q == nsteps_q - STEP_ONE);
   // A zero window still spends one cycle so the two triggers stay at least 3 cycles apart.
   assign window_end   = (window_q == '0) || (cnt_q == window_q - CNT_ONE);
   // The trigger cycle itself (cnt 0) is outside the detector response window.
   assign snap_hit     = bus.pd_data_valid && (cnt_q != '0);
   assign snap_timeout = (cnt_q == TIMEOUT_CNT);
   assign freq_d       = freq_q + step_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         settle_q    <= '0;
         window_q    <= '0;
         step_q      <= '0;
         nsteps_q    <= '0;
         index_q     <= '0;
         a_i_q       <= '0;
         a_q_q       <= '0;
         freq_q      <= '0;
         trig_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_index_q <= '0;
         res_freq_q  <= '0;
         res_i_q     <= '0;
         res_q_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         sticky_q    <= 1'b0;
      end else begin
         trig_q      <= 1'b0;
         res_valid_q <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         if (bus.abort && (state_q != IDLE)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (bus.start && !bus.abort) begin
                     if (bus.num_steps == '0) begin
                        done_q <= 1'b1;
                     end else begin
                        settle_q <= bus.settle_cycles;
                        window_q <= bus.window_cycles;
                        step_q   <= bus.step_freq;
                        nsteps_q <= bus.num_steps;
                        freq_q   <= bus.start_freq;
                        index_q  <= '0;
                        sticky_q <= 1'b0;
                        trig_q   <= 1'b1;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= PRIME;
                     end
                  end
               end
               PRIME: begin
                  if (cnt_q == PRIME_LAST) begin
                     cnt_q <= '0;
                     if (settle_q == '0) begin
                        trig_q  <= 1'b1;
                        state_q <= SNAP_A;
                     end else begin
                        state_q <= SETTLE;
                     end
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               SETTLE: begin
                  if (cnt_q == settle_q - CNT_ONE) begin
                     cnt_q   <= '0;
                     trig_q  <= 1'b1;
                     state_q <= SNAP_A;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               SNAP_A: begin
                  if (snap_hit) begin
                     a_i_q   <= bus.pd_i;
                     a_q_q   <= bus.pd_q;
                     cnt_q   <= '0;
                     state_q <= WINDOW;
                  end else if (snap_timeout) begin
                     error_q  <= 1'b1;
                     sticky_q <= 1'b1;
                     busy_q   <= 1'b0;
                     state_q  <= IDLE;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               WINDOW: begin
                  if (window_end) begin
                     cnt_q   <= '0;
                     trig_q  <= 1'b1;
                     state_q <= SNAP_B;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               SNAP_B: begin
                  if (snap_hit) begin
                     // Detector sums free-run, so the window value is the wrapped difference.
                     res_i_q     <= bus.pd_i - a_i_q;
                     res_q_q     <= bus.pd_q - a_q_q;
                     res_index_q <= index_q;
                     res_freq_q  <= freq_q;
                     res_valid_q <= 1'b1;
                     done_q      <= last_step;
                     state_q     <= EMIT;
                  end else if (snap_timeout) begin
                     error_q  <= 1'b1;
                     sticky_q <= 1'b1;
                     busy_q   <= 1'b0;
                     state_q  <= IDLE;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               EMIT: begin
                  if (last_step) begin
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     freq_q  <= freq_d;
                     index_q <= index_q + STEP_ONE;
                     cnt_q   <= '0;
                     if (settle_q == '0) begin
                        trig_q  <= 1'b1;
                        state_q <= SNAP_A;
                     end else begin
                        state_q <= SETTLE;
                     end
                  end
               end
               default: begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.freq_word    = freq_q;
   assign bus.pd_trigger   = trig_q;
   assign bus.result_valid = res_valid_q;
   assign bus.result_index = res_index_q;
   assign bus.result_freq  = res_freq_q;
   assign bus.result_i     = res_i_q;
   assign bus.result_q     = res_q_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.error        = error_q;
   assign bus.err_sticky   = sticky_q;
endmodule

// File: tb/tb_sweep_scheduler.sv
// Bench for sweep_scheduler: detector model answering 3 cycles after each trigger,
// scoreboard of expected results, table of sweep configurations plus corner-case sequences.
module tb_sweep_scheduler;
   localparam int FREQ_W  = 32;
   localparam int STEP_W  = 16;
   localparam int CNT_W   = 24;
   localparam int TIMEOUT = 64;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #10 clk = ~clk;

   sweep_scheduler_if #(.FREQ_W(FREQ_W), .STEP_W(STEP_W), .CNT_W(CNT_W)) bus ();

   sweep_scheduler #(
      .FREQ_W(FREQ_W), .STEP_W(STEP_W), .CNT_W(CNT_W), .PRIME_CYCLES(8), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   typedef struct {
      logic [31:0] idx;
      logic [31:0] freq;
      logic [31:0] ri;
      logic [31:0] rq;
   } exp_t;

   typedef struct {
      logic [31:0] sf;
      logic [31:0] sp;
      logic [15:0] ns;
      logic [23:0] st;
      logic [23:0] wn;
      int          exp_res;
      int          exp_trig;
      logic [31:0] exp_last;
   } vec_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   int   cyc = 0;
   int   cd = 0;
   int   cd_phase = 0;
   int   trig_n = 0;
   int   last_trig = -100;
   int   a_trig_cyc = 0;
   int   n_res = 0;
   int   n_done = 0;
   int   n_errp = 0;
   int   done_cyc = 0;
   int   err_cyc = 0;
   int   last_res_cyc = 0;
   logic [31:0] last_res_idx = '0;
   logic [31:0] res_i_last = '0;
   logic [31:0] res_q_last = '0;
   logic [31:0] ex_idx = '0;
   logic [31:0] cfg_start = '0;
   logic [31:0] cfg_step = '0;
   logic [31:0] acc_i = 32'h0000_1000;
   logic [31:0] acc_q = 32'h0000_0000;
   logic [31:0] a_i = '0;
   logic [31:0] a_q = '0;
   bit   model_en = 1'b1;
   bit   fixed_mode = 1'b0;
   logic [31:0] fa_i = 32'hFFFF_FFF0;
   logic [31:0] fb_i = 32'h0000_0010;
   logic [31:0] fa_q = 32'h0000_0010;
   logic [31:0] fb_q = 32'h0000_0004;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One clock: detector model and output monitor run on the falling edge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      cyc++;
      acc_i = acc_i + 32'h0001_3579;
      acc_q = acc_q - 32'h0000_2468;
      bus.pd_data_valid = 1'b0;
      bus.pd_i = acc_i;
      bus.pd_q = acc_q;
      if (!reset_n) cd = 0;
      if (cd > 0) begin
         cd--;
         if (cd == 0 && model_en) begin
            bus.pd_data_valid = 1'b1;
            if (fixed_mode && cd_phase == 1) begin
               bus.pd_i = fa_i;
               bus.pd_q = fa_q;
            end
            if (fixed_mode && cd_phase == 2) begin
               bus.pd_i = fb_i;
               bus.pd_q = fb_q;
            end
            if (cd_phase == 1) begin
               a_i = bus.pd_i;
               a_q = bus.pd_q;
            end
            if (cd_phase == 2) begin
               e.idx  = ex_idx;
               e.freq = cfg_start + ex_idx * cfg_step;
               e.ri   = bus.pd_i - a_i;
               e.rq   = bus.pd_q - a_q;
               sb.push_back(e);
               ex_idx = ex_idx + 1;
            end
         end
      end
      if (bus.pd_trigger) begin
         chk("trig_spacing_ge3", 64'(cyc - last_trig >= 3), 64'd1);
         last_trig = cyc;
         cd = 3;
         cd_phase = (trig_n == 0) ? 0 : ((trig_n % 2 == 1) ? 1 : 2);
         if (trig_n == 1) a_trig_cyc = cyc;
         trig_n++;
      end
      if (bus.result_valid) begin
         n_res++;
         last_res_cyc = cyc;
         last_res_idx = 32'(bus.result_index);
         res_i_last = bus.result_i;
         res_q_last = bus.result_q;
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_result: index %0d, expected no result", bus.result_index);
         end else begin
            e = sb.pop_front();
            chk("result_index", 64'(bus.result_index), 64'(e.idx[15:0]));
            chk("result_freq", 64'(bus.result_freq), 64'(e.freq));
            chk("result_i", 64'(bus.result_i), 64'(e.ri));
            chk("result_q", 64'(bus.result_q), 64'(e.rq));
         end
      end
      if (bus.done) begin
         n_done++;
         done_cyc = cyc;
      end
      if (bus.error) begin
         n_errp++;
         err_cyc = cyc;
      end
   endtask

   task automatic run_start(input logic [31:0] sf, input logic [31:0] sp, input logic [15:0] ns,
                            input logic [23:0] st, input logic [23:0] wn, input logic ab);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      sb.delete();
      bus.start_freq    = sf;
      bus.step_freq     = sp;
      bus.num_steps     = ns;
      bus.settle_cycles = st;
      bus.window_cycles = wn;
      bus.start         = 1'b1;
      bus.abort         = ab;
      trig_n = 0;
      ex_idx = '0;
      cfg_start = sf;
      cfg_step = sp;
      n_res = 0;
      n_done = 0;
      n_errp = 0;
      tick();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      // Scrambled config must have no effect on the running sweep.
      bus.start_freq    = ~sf;
      bus.step_freq     = 32'h0000_0005;
      bus.num_steps     = ns + 16'd7;
      bus.settle_cycles = 24'd0;
      bus.window_cycles = 24'd3;
   endtask

   task automatic wait_idle(input int budget, input string nm);
      int k = 0;
      while (bus.busy && k < budget) begin
         tick();
         k++;
      end
      chk(nm, 64'(bus.busy), 64'd0);
   endtask

   task automatic wait_trig(input int n, input string nm);
      int k = 0;
      while (trig_n < n && k < 1000) begin
         tick();
         k++;
      end
      chk(nm, 64'(trig_n), 64'(n));
   endtask

   vec_t vt[4];

   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.start_freq = '0;
      bus.step_freq = '0;
      bus.num_steps = '0;
      bus.settle_cycles = '0;
      bus.window_cycles = '0;
      bus.pd_data_valid = 1'b0;
      bus.pd_i = '0;
      bus.pd_q = '0;

      vt[0] = '{32'd1000, 32'd250, 16'd3, 24'd4, 24'd10, 3, 7, 32'd1500};
      vt[1] = '{32'hFFFF_FF00, 32'h80, 16'd4, 24'd0, 24'd0, 4, 9, 32'h0000_0080};
      vt[2] = '{32'd5, 32'hFFFF_FFFF, 16'd2, 24'd1, 24'd1, 2, 5, 32'd4};
      vt[3] = '{32'h1234_5678, 32'h1000, 16'd5, 24'd7, 24'd3, 5, 11, 32'h1234_9678};

      repeat (3) tick();
      chk("reset_flags", 64'({bus.busy, bus.pd_trigger, bus.result_valid, bus.done,
                              bus.error, bus.err_sticky}), 64'd0);
      chk("reset_freq_word", 64'(bus.freq_word), 64'd0);
      reset_n = 1'b1;
      repeat (2) tick();

      for (int v = 0; v < 4; v++) begin
         run_start(vt[v].sf, vt[v].sp, vt[v].ns, vt[v].st, vt[v].wn, 1'b0);
         chk("busy_on_accept", 64'(bus.busy), 64'd1);
         chk("trig_on_accept", 64'(bus.pd_trigger), 64'd1);
         chk("freq_on_accept", 64'(bus.freq_word), 64'(vt[v].sf));
         tick();
         chk("trig_single_cycle", 64'(bus.pd_trigger), 64'd0);
         wait_idle(2000, "sweep_completes");
         chk("result_count", 64'(n_res), 64'(vt[v].exp_res));
         chk("done_count", 64'(n_done), 64'd1);
         chk("done_with_last_result", 64'(done_cyc), 64'(last_res_cyc));
         chk("busy_drop_after_done", 64'(cyc), 64'(done_cyc + 1));
         chk("trigger_count", 64'(trig_n), 64'(vt[v].exp_trig));
         chk("freq_word_holds_last", 64'(bus.freq_word), 64'(vt[v].exp_last));
         chk("last_result_index", 64'(last_res_idx), 64'(vt[v].exp_res - 1));
         repeat (3) tick();
      end

      // Snapshot differencing across the 32-bit wrap.
      fixed_mode = 1'b1;
      run_start(32'd100, 32'd1, 16'd1, 24'd2, 24'd5, 1'b0);
      wait_idle(500, "fixed_sweep_completes");
      chk("fixed_result_count", 64'(n_res), 64'd1);
      chk("fixed_result_i", 64'(res_i_last), 64'h20);
      chk("fixed_result_q", 64'(res_q_last), 64'hFFFF_FFF4);
      fixed_mode = 1'b0;
      repeat (3) tick();

      // Detector never answers: timeout from the SNAP_A trigger.
      model_en = 1'b0;
      run_start(32'd7, 32'd1, 16'd2, 24'd3, 24'd4, 1'b0);
      wait_idle(300, "timeout_returns_idle");
      chk("timeout_error_pulses", 64'(n_errp), 64'd1);
      chk("timeout_error_cycle", 64'(err_cyc), 64'(a_trig_cyc + TIMEOUT + 1));
      chk("timeout_sticky_set", 64'(bus.err_sticky), 64'd1);
      chk("timeout_no_result", 64'(n_res), 64'd0);
      repeat (5) tick();
      chk("sticky_holds_idle", 64'(bus.err_sticky), 64'd1);
      model_en = 1'b1;
      run_start(32'd7, 32'd1, 16'd1, 24'd0, 24'd2, 1'b0);
      chk("sticky_cleared_by_start", 64'(bus.err_sticky), 64'd0);
      wait_idle(500, "post_timeout_sweep_completes");
      chk("post_timeout_result_count", 64'(n_res), 64'd1);
      repeat (3) tick();

      // Abort inside the window of step 1 of 3.
      run_start(32'd1000, 32'd250, 16'd3, 24'd4, 24'd10, 1'b0);
      wait_trig(4, "abort_reach_step1_snap_a");
      repeat (6) tick();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("abort_busy_low", 64'(bus.busy), 64'd0);
      repeat (40) tick();
      chk("abort_result_count", 64'(n_res), 64'd1);
      chk("abort_no_done", 64'(n_done), 64'd0);
      chk("abort_no_more_triggers", 64'(trig_n), 64'd4);
      run_start(32'd1000, 32'd250, 16'd3, 24'd4, 24'd10, 1'b0);
      wait_idle(2000, "rerun_completes");
      chk("rerun_result_count", 64'(n_res), 64'd3);
      repeat (3) tick();

      // Zero steps: immediate done, nothing else.
      run_start(32'd5, 32'd5, 16'd0, 24'd1, 24'd1, 1'b0);
      chk("zero_steps_done", 64'(bus.done), 64'd1);
      chk("zero_steps_busy", 64'(bus.busy), 64'd0);
      repeat (5) tick();
      chk("zero_steps_done_count", 64'(n_done), 64'd1);
      chk("zero_steps_no_trigger", 64'(trig_n), 64'd0);

      // Start and abort together: not accepted.
      run_start(32'd5, 32'd5, 16'd3, 24'd1, 24'd1, 1'b1);
      chk("start_abort_busy", 64'(bus.busy), 64'd0);
      repeat (10) tick();
      chk("start_abort_no_trigger", 64'(trig_n), 64'd0);
      chk("start_abort_no_done", 64'(n_done), 64'd0);

      // Asynchronous reset in the middle of SNAP_B.
      run_start(32'd2000, 32'd10, 16'd2, 24'd2, 24'd3, 1'b0);
      wait_trig(3, "reset_reach_snap_b");
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_flags", 64'({bus.busy, bus.pd_trigger, bus.result_valid, bus.done,
                                    bus.error, bus.err_sticky}), 64'd0);
      chk("async_reset_freq_word", 64'(bus.freq_word), 64'd0);
      cd = 0;
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (2) tick();
      chk("reset_idle_after_release", 64'(bus.busy), 64'd0);
      run_start(32'd2000, 32'd10, 16'd2, 24'd2, 24'd3, 1'b0);
      wait_idle(1000, "post_reset_sweep_completes");
      chk("post_reset_result_count", 64'(n_res), 64'd2);
      chk("post_reset_done_count", 64'(n_done), 64'd1);
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
